// File: rtl/mips_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mips_multicycle_ctrl
// Purpose  : Multi-cycle MIPS controller FSM. Walks each instruction through
//            FETCH/DECODE/EXEC/MEM/WB over a shared variable-latency memory
//            (req/ready handshake). It also traps illegal opcodes, detects
//            memory timeouts and counts retired instructions.
// Ports    : clk, reset (sync, active-high)
//            opcode, funct, zero, mem_ready          - inputs
//            mem_req, mem_we, i_or_d, ir_write,       - memory / IR / PC control
//            pc_write, pc_write_cond, pc_src
//            alu_src_a, alu_src_b, ext_op, alu_op     - ALU control
//            reg_write, reg_dst, mem_to_reg           - register-file control
//            illegal, fault, retired, state_dbg       - status / debug
// Revision : 1.0 - initial release
// ============================================================================
module mips_multicycle_ctrl #(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 4,
    parameter int RET_W   = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             i_or_d,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic [1:0]       pc_src,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic             ext_op,
    output logic [2:0]       alu_op,
    output logic             reg_write,
    output logic [1:0]       reg_dst,
    output logic [1:0]       mem_to_reg,
    output logic             illegal,
    output logic             fault,
    output logic [RET_W-1:0] retired,
    output logic [3:0]       state_dbg
);

    localparam logic [3:0] c_fetch    = 4'd0;
    localparam logic [3:0] c_decode   = 4'd1;
    localparam logic [3:0] c_exec_r   = 4'd2;
    localparam logic [3:0] c_wb_r     = 4'd3;
    localparam logic [3:0] c_exec_i   = 4'd4;
    localparam logic [3:0] c_wb_i     = 4'd5;
    localparam logic [3:0] c_mem_addr = 4'd6;
    localparam logic [3:0] c_mem_rd   = 4'd7;
    localparam logic [3:0] c_mem_wb   = 4'd8;
    localparam logic [3:0] c_mem_wr   = 4'd9;
    localparam logic [3:0] c_branch   = 4'd10;
    localparam logic [3:0] c_jump     = 4'd11;
    localparam logic [3:0] c_jal      = 4'd12;
    localparam logic [3:0] c_jr       = 4'd13;
    localparam logic [3:0] c_fault    = 4'd14;
    localparam logic [3:0] c_illegal  = 4'd15;

    localparam logic [5:0] c_op_rtype = 6'b000000;
    localparam logic [5:0] c_op_lw    = 6'b100011;
    localparam logic [5:0] c_op_sw    = 6'b101011;
    localparam logic [5:0] c_op_ori   = 6'b001101;
    localparam logic [5:0] c_op_lui   = 6'b001111;
    localparam logic [5:0] c_op_beq   = 6'b000100;
    localparam logic [5:0] c_op_j     = 6'b000010;
    localparam logic [5:0] c_op_jal   = 6'b000011;

    localparam logic [5:0] c_fn_jr    = 6'b001000;
    localparam logic [5:0] c_fn_addu  = 6'b100001;
    localparam logic [5:0] c_fn_subu  = 6'b100011;
    localparam logic [5:0] c_fn_sll   = 6'b000000;

    localparam logic [CNT_W-1:0] c_wait_limit = CNT_W'(TIMEOUT - 1);

    logic [3:0]       r_state;
    logic [3:0]       w_next;
    logic [CNT_W-1:0] r_wait;
    logic [RET_W-1:0] r_retired;
    logic             w_mem_state;
    logic             w_timeout;
    logic             w_unused_zero;

    // The zero flag is combined with pc_write_cond in the datapath PC enable.
    assign w_unused_zero = zero;

    assign w_mem_state = (r_state == c_fetch) || (r_state == c_mem_rd) ||
                         (r_state == c_mem_wr);
    // A ready on the limit cycle takes priority: timeout needs !mem_ready.
    assign w_timeout   = w_mem_state && !mem_ready && (r_wait == c_wait_limit);

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_fetch: begin
                if (mem_ready)      w_next = c_decode;
                else if (w_timeout) w_next = c_fault;
            end
            c_decode: begin
                case (opcode)
                    c_op_rtype: begin
                        if (funct == c_fn_jr)
                            w_next = c_jr;
                        else if (funct == c_fn_addu || funct == c_fn_subu ||
                                 funct == c_fn_sll)
                            w_next = c_exec_r;
                        else
                            w_next = c_illegal;
                    end
                    c_op_lw, c_op_sw:   w_next = c_mem_addr;
                    c_op_ori, c_op_lui: w_next = c_exec_i;
                    c_op_beq:           w_next = c_branch;
                    c_op_j:             w_next = c_jump;
                    c_op_jal:           w_next = c_jal;
                    default:            w_next = c_illegal;
                endcase
            end
            c_exec_r:   w_next = c_wb_r;
            c_exec_i:   w_next = c_wb_i;
            c_mem_addr: w_next = (opcode == c_op_lw) ? c_mem_rd : c_mem_wr;
            c_mem_rd: begin
                if (mem_ready)      w_next = c_mem_wb;
                else if (w_timeout) w_next = c_fault;
            end
            c_mem_wr: begin
                if (mem_ready)      w_next = c_fetch;
                else if (w_timeout) w_next = c_fault;
            end
            c_wb_r, c_wb_i, c_mem_wb, c_branch, c_jump, c_jal, c_jr:
                w_next = c_fetch;
            c_fault:    w_next = c_fault;
            default:    w_next = c_illegal;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= c_fetch;
            r_wait    <= '0;
            r_retired <= '0;
        end else begin
            r_state <= w_next;
            // Counter is zero outside memory states, so every entry starts at 0.
            if (w_mem_state && !mem_ready && !w_timeout)
                r_wait <= r_wait + CNT_W'(1);
            else
                r_wait <= '0;
            if (r_state != c_fetch && w_next == c_fetch)
                r_retired <= r_retired + RET_W'(1);
        end
    end

    // Outputs are decoded from the current state (plus mem_ready in FETCH)
    // and are all forced low while reset is asserted.
    always_comb begin
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        i_or_d        = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_src        = 2'd0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'd0;
        ext_op        = 1'b0;
        alu_op        = 3'b000;
        reg_write     = 1'b0;
        reg_dst       = 2'd0;
        mem_to_reg    = 2'd0;
        illegal       = 1'b0;
        fault         = 1'b0;
        retired       = '0;
        state_dbg     = 4'd0;
        if (!reset) begin
            state_dbg = r_state;
            retired   = r_retired;
            case (r_state)
                c_fetch: begin
                    mem_req   = 1'b1;
                    alu_src_b = 2'd1;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                c_decode: begin
                    alu_src_b = 2'd3;
                    ext_op    = 1'b1;
                end
                c_exec_r: begin
                    alu_src_a = 1'b1;
                    alu_op    = 3'b100;
                end
                c_wb_r: begin
                    reg_write = 1'b1;
                    reg_dst   = 2'd1;
                end
                c_exec_i: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'd2;
                    alu_op    = (opcode == c_op_lui) ? 3'b011 : 3'b010;
                end
                c_wb_i: reg_write = 1'b1;
                c_mem_addr: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'd2;
                    ext_op    = 1'b1;
                end
                c_mem_rd: begin
                    mem_req = 1'b1;
                    i_or_d  = 1'b1;
                end
                c_mem_wb: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 2'd1;
                end
                c_mem_wr: begin
                    mem_req = 1'b1;
                    mem_we  = 1'b1;
                    i_or_d  = 1'b1;
                end
                c_branch: begin
                    alu_src_a     = 1'b1;
                    alu_op        = 3'b001;
                    pc_write_cond = 1'b1;
                    pc_src        = 2'd1;
                end
                c_jump: begin
                    pc_write = 1'b1;
                    pc_src   = 2'd2;
                end
                c_jal: begin
                    // Register file captures the already-incremented PC.
                    pc_write   = 1'b1;
                    pc_src     = 2'd2;
                    reg_write  = 1'b1;
                    reg_dst    = 2'd2;
                    mem_to_reg = 2'd2;
                end
                c_jr: begin
                    pc_write = 1'b1;
                    pc_src   = 2'd3;
                end
                c_fault:   fault   = 1'b1;
                default:   illegal = 1'b1;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mips_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_multicycle_ctrl
// Purpose  : Self-checking bench for mips_multicycle_ctrl. Each scenario queues
//            per-cycle stimulus together with the expected controller outputs;
//            the queue is then drained one clock at a time and compared.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mips_multicycle_ctrl;

    logic        clk;
    logic        reset;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        zero;
    logic        mem_ready;
    logic        mem_req, mem_we, i_or_d, ir_write, pc_write, pc_write_cond;
    logic [1:0]  pc_src;
    logic        alu_src_a;
    logic [1:0]  alu_src_b;
    logic        ext_op;
    logic [2:0]  alu_op;
    logic        reg_write;
    logic [1:0]  reg_dst;
    logic [1:0]  mem_to_reg;
    logic        illegal, fault;
    logic [31:0] retired;
    logic [3:0]  state_dbg;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       i_or_d;
        logic       ir_write;
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       ext_op;
        logic [2:0] alu_op;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       illegal;
        logic       fault;
    } outs_t;

    typedef struct packed {
        outs_t       o;
        logic        rdy;
        logic        zf;
        logic        rst;
        logic        last;
        logic        is_fetch;
        logic [63:0] tag;
    } item_t;

    item_t       sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_ret = 0;

    mips_multicycle_ctrl #(.TIMEOUT(15), .CNT_W(4), .RET_W(32)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
        .i_or_d(i_or_d), .ir_write(ir_write), .pc_write(pc_write),
        .pc_write_cond(pc_write_cond), .pc_src(pc_src), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .ext_op(ext_op), .alu_op(alu_op),
        .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .illegal(illegal), .fault(fault), .retired(retired),
        .state_dbg(state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected output vectors, one per controller state.
    function automatic outs_t e_none();
        outs_t o = '0;
        return o;
    endfunction
    function automatic outs_t e_fetch(input logic rdy);
        outs_t o = '0;
        o.mem_req = 1'b1; o.alu_src_b = 2'd1;
        o.ir_write = rdy; o.pc_write = rdy;
        return o;
    endfunction
    function automatic outs_t e_decode();
        outs_t o = '0;
        o.alu_src_b = 2'd3; o.ext_op = 1'b1;
        return o;
    endfunction
    function automatic outs_t e_exec_r();
        outs_t o = '0;
        o.alu_src_a = 1'b1; o.alu_op = 3'b100;
        return o;
    endfunction
    function automatic outs_t e_wb_r();
        outs_t o = '0;
        o.reg_write = 1'b1; o.reg_dst = 2'd1;
        return o;
    endfunction
    function automatic outs_t e_exec_i(input logic [2:0] op);
        outs_t o = '0;
        o.alu_src_a = 1'b1; o.alu_src_b = 2'd2; o.alu_op = op;
        return o;
    endfunction
    function automatic outs_t e_wb_i();
        outs_t o = '0;
        o.reg_write = 1'b1;
        return o;
    endfunction
    function automatic outs_t e_mem_addr();
        outs_t o = '0;
        o.alu_src_a = 1'b1; o.alu_src_b = 2'd2; o.ext_op = 1'b1;
        return o;
    endfunction
    function automatic outs_t e_mem_rd();
        outs_t o = '0;
        o.mem_req = 1'b1; o.i_or_d = 1'b1;
        return o;
    endfunction
    function automatic outs_t e_mem_wb();
        outs_t o = '0;
        o.reg_write = 1'b1; o.mem_to_reg = 2'd1;
        return o;
    endfunction
    function automatic outs_t e_mem_wr();
        outs_t o = '0;
        o.mem_req = 1'b1; o.mem_we = 1'b1; o.i_or_d = 1'b1;
        return o;
    endfunction
    function automatic outs_t e_branch();
        outs_t o = '0;
        o.alu_src_a = 1'b1; o.alu_op = 3'b001;
        o.pc_write_cond = 1'b1; o.pc_src = 2'd1;
        return o;
    endfunction
    function automatic outs_t e_jump(input logic [1:0] src);
        outs_t o = '0;
        o.pc_write = 1'b1; o.pc_src = src;
        return o;
    endfunction
    function automatic outs_t e_jal();
        outs_t o = '0;
        o.pc_write = 1'b1; o.pc_src = 2'd2;
        o.reg_write = 1'b1; o.reg_dst = 2'd2; o.mem_to_reg = 2'd2;
        return o;
    endfunction
    function automatic outs_t e_fault();
        outs_t o = '0;
        o.fault = 1'b1;
        return o;
    endfunction
    function automatic outs_t e_illegal();
        outs_t o = '0;
        o.illegal = 1'b1;
        return o;
    endfunction

    task automatic push(input outs_t o, input logic rdy, input logic zf,
                        input logic rst, input logic last, input logic is_fetch,
                        input logic [63:0] tag);
        item_t it;
        it.o = o; it.rdy = rdy; it.zf = zf; it.rst = rst;
        it.last = last; it.is_fetch = is_fetch; it.tag = tag;
        sb.push_back(it);
    endtask

    task automatic push_fetch(input int waits);
        for (int i = 0; i < waits; i++)
            push(e_fetch(1'b0), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "fetchwt");
        push(e_fetch(1'b1), 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, "fetch");
    endtask

    task automatic push_reset();
        push(e_none(), 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, "reset");
    endtask

    // Drive one queued cycle at a time, sample before the next rising edge.
    task automatic drain();
        item_t it;
        outs_t act;
        logic [31:0] want_ret;
        while (sb.size() > 0) begin
            it        = sb.pop_front();
            reset     = it.rst;
            mem_ready = it.rdy;
            zero      = it.zf;
            #4;
            act = {mem_req, mem_we, i_or_d, ir_write, pc_write, pc_write_cond,
                   pc_src, alu_src_a, alu_src_b, ext_op, alu_op, reg_write,
                   reg_dst, mem_to_reg, illegal, fault};
            want_ret = it.rst ? 32'd0 : exp_ret;
            checks++;
            if (act !== it.o) begin
                errors++;
                $display("FAIL %0s outputs actual=%h required=%h", it.tag, act, it.o);
            end
            checks++;
            if (retired !== want_ret) begin
                errors++;
                $display("FAIL %0s retired actual=%0d required=%0d", it.tag, retired, want_ret);
            end
            checks++;
            if ((state_dbg === 4'd0) !== it.is_fetch) begin
                errors++;
                $display("FAIL %0s state_dbg actual=%0d required_fetch=%0b", it.tag, state_dbg, it.is_fetch);
            end
            if (it.rst)       exp_ret = 32'd0;
            else if (it.last) exp_ret = exp_ret + 32'd1;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        push_reset();
        push_reset();
        drain();
    endtask

    task automatic test_addu();
        opcode = 6'b000000; funct = 6'b100001;
        push_fetch(0);
        push(e_decode(), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "decode");
        push(e_exec_r(), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "exec_r");
        push(e_wb_r(),   1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "wb_r");
        drain();
    endtask

    task automatic test_lw_waits();
        opcode = 6'b100011; funct = 6'b000000;
        push_fetch(3);
        push(e_decode(),   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "decode");
        push(e_mem_addr(), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "memaddr");
        push(e_mem_rd(),   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "memrdwt");
        push(e_mem_rd(),   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "memrdwt");
        push(e_mem_rd(),   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "memrd");
        push(e_mem_wb(),   1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "memwb");
        drain();
    endtask

    task automatic test_sw();
        opcode = 6'b101011;
        push_fetch(1);
        push(e_decode(),   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "decode");
        push(e_mem_addr(), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "memaddr");
        push(e_mem_wr(),   1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "memwr");
        drain();
    endtask

    task automatic test_imm(input logic [5:0] op, input logic [2:0] aluop);
        opcode = op;
        push_fetch(0);
        push(e_decode(),       1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "decode");
        push(e_exec_i(aluop),  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "exec_i");
        push(e_wb_i(),         1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "wb_i");
        drain();
    endtask

    task automatic test_branch(input logic zf);
        opcode = 6'b000100;
        push_fetch(0);
        push(e_decode(), 1'b1, zf, 1'b0, 1'b0, 1'b0, "decode");
        push(e_branch(), 1'b1, zf, 1'b0, 1'b1, 1'b0, "branch");
        drain();
    endtask

    task automatic test_jumps();
        opcode = 6'b000010;
        push_fetch(0);
        push(e_decode(),      1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "decode");
        push(e_jump(2'd2),    1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "jump");
        drain();
        opcode = 6'b000011;
        push_fetch(0);
        push(e_decode(),      1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "decode");
        push(e_jal(),         1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "jal");
        drain();
        opcode = 6'b000000; funct = 6'b001000;
        push_fetch(0);
        push(e_decode(),      1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "decode");
        push(e_jump(2'd3),    1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "jr");
        drain();
    endtask

    task automatic test_back_to_back();
        opcode = 6'b000000; funct = 6'b100011;
        push_fetch(0);
        push(e_decode(), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "decode");
        push(e_exec_r(), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "exec_r");
        push(e_wb_r(),   1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "wb_subu");
        drain();
        funct = 6'b000000;
        push_fetch(0);
        push(e_decode(), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "decode");
        push(e_exec_r(), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "exec_r");
        push(e_wb_r(),   1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "wb_nop");
        drain();
    endtask

    task automatic test_timeout_edge();
        opcode = 6'b000010;
        push_fetch(14);
        push(e_decode(),   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "decode");
        push(e_jump(2'd2), 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "jump");
        drain();
    endtask

    task automatic test_timeout_fault();
        opcode = 6'b000010;
        for (int i = 0; i < 15; i++)
            push(e_fetch(1'b0), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "fetchwt");
        for (int i = 0; i < 3; i++)
            push(e_fault(), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "fault");
        push_reset();
        push_fetch(0);
        push(e_decode(),   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "decode");
        push(e_jump(2'd2), 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "jump");
        drain();
    endtask

    task automatic test_illegal();
        opcode = 6'b111111;
        push_fetch(0);
        push(e_decode(),  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "decode");
        push(e_illegal(), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "illegal");
        push(e_illegal(), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "illegal");
        push_reset();
        drain();
        opcode = 6'b000000; funct = 6'b100000;
        push_fetch(0);
        push(e_decode(),  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "decode");
        push(e_illegal(), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "ill_fn");
        push_reset();
        drain();
    endtask

    task automatic test_reset_mid_wr();
        opcode = 6'b101011;
        push_fetch(0);
        push(e_decode(),   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "decode");
        push(e_mem_addr(), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "memaddr");
        push(e_mem_wr(),   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "memwrwt");
        push_reset();
        push_fetch(0);
        push(e_decode(),   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "decode");
        push(e_mem_addr(), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "memaddr");
        push(e_mem_wr(),   1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "memwr");
        drain();
    endtask

    initial begin
        reset = 1'b1; mem_ready = 1'b1; zero = 1'b0;
        opcode = 6'b000000; funct = 6'b000000;
        @(posedge clk);
        #1;
        test_reset();
        test_addu();
        test_lw_waits();
        test_sw();
        test_imm(6'b001101, 3'b010);
        test_imm(6'b001111, 3'b011);
        test_branch(1'b1);
        test_branch(1'b0);
        test_jumps();
        test_back_to_back();
        test_timeout_edge();
        test_timeout_fault();
        test_illegal();
        test_reset_mid_wr();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Parametrised multi-cycle controller FSM for the next-generation MIPS core. It replaces the single-cycle combinational controller.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states over a shared, variable-latency memory with a req/ready handshake.
- Supports R-type (incl. nop), lw, sw, lui, ori, j, jal, jr, beq.
- Adds memory wait-states, a timeout fault, illegal-opcode trapping and a retired-instruction counter.

Parameters:
TIMEOUT, 15, max wait cycles per memory access before FAULT (1..2^CNT_W-1)
CNT_W, 4, width of wait counter
RET_W, 32, width of retired-instruction counter

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high
opcode  in  6  IR[31:26], valid from DECODE onward
funct  in  6  IR[5:0]
zero  in  1  ALU zero flag (beq)
mem_ready  in  1  memory access completes this cycle
mem_req  out  1  memory access request
mem_we  out  1  write (with mem_req)
i_or_d  out  1  0 = PC address, 1 = ALUOut address
ir_write  out  1  latch IR
pc_write  out  1  unconditional PC update
pc_write_cond  out  1  PC update if zero=1
pc_src  out  2  0 ALU, 1 ALUOut, 2 jump target, 3 rs
alu_src_a  out  1  0 PC, 1 rs
alu_src_b  out  2  0 rt, 1 const 4, 2 extended imm, 3 sign imm<<2
ext_op  out  1  0 zero-extend, 1 sign-extend
alu_op  out  3  000 add, 001 sub, 010 or, 011 lui, 100 decode by funct
reg_write  out  1  register-file write enable
reg_dst  out  2  0 rt, 1 rd, 2 $31
mem_to_reg  out  2  0 ALUOut, 1 MDR, 2 PC
illegal  out  1  sticky: unknown opcode/funct trapped
fault  out  1  sticky: memory timeout
retired  out  RET_W  count of completed instructions
state_dbg  out  4  current state encoding

Behaviour:
- Reset: one synchronous cycle with reset=1 forces state=FETCH, wait counter=0, retired=0, illegal=0, fault=0. All outputs are 0 in the reset cycle. Reset overrides any state, including mid-access and FAULT/ILLEGAL.
- Outputs not listed for a state are 0.
- FETCH: mem_req=1, i_or_d=0, alu_src_a=0, alu_src_b=1, alu_op=add.
  - If mem_ready: ir_write=1, pc_write=1, pc_src=0 (Mealy, same cycle), go to DECODE.
  - Else: counter+1.
- DECODE: alu_src_a=0, alu_src_b=3, ext_op=1, alu_op=add (branch target into ALUOut). Dispatch on opcode:
  - 000000 with funct 001000 -> JR; other funct -> EXEC_R. Legal R-type funct: 100001 addu, 100011 subu, 000000 sll/nop; all others -> ILLEGAL.
  - 100011 / 101011 -> MEM_ADDR
  - 001101 / 001111 -> EXEC_I
  - 000100 -> BRANCH
  - 000010 -> JUMP
  - 000011 -> JAL
  - other -> ILLEGAL
- EXEC_R: alu_src_a=1, alu_src_b=0, alu_op=100 -> WB_R.
- WB_R: reg_write=1, reg_dst=1, mem_to_reg=0 -> FETCH.
- EXEC_I: alu_src_a=1, alu_src_b=2, ext_op=0, alu_op=or (ori) / lui -> WB_I.
- WB_I: reg_write=1, reg_dst=0, mem_to_reg=0 -> FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=2, ext_op=1, alu_op=add -> MEM_RD (lw) or MEM_WR (sw).
- MEM_RD: mem_req=1, i_or_d=1; wait for mem_ready -> MEM_WB.
- MEM_WB: reg_write=1, reg_dst=0, mem_to_reg=1 -> FETCH.
- MEM_WR: mem_req=1, mem_we=1, i_or_d=1; wait for mem_ready -> FETCH.
- BRANCH: alu_src_a=1, alu_src_b=0, alu_op=sub, pc_write_cond=1, pc_src=1 -> FETCH.
- JUMP: pc_write=1, pc_src=2 -> FETCH.
- JAL: pc_write=1, pc_src=2, reg_write=1, reg_dst=2, mem_to_reg=2 -> FETCH. The register file samples PC before the PC edge, i.e. PC+4 of the jal.
- JR: pc_write=1, pc_src=3 -> FETCH.
- Wait counter: cleared on entering any memory state and on mem_ready. In a memory state with mem_ready=0, if counter==TIMEOUT-1, go to FAULT instead of incrementing. mem_ready on the same cycle as the limit wins (no fault).
- FAULT: fault=1, all enables 0, stays until reset.
- ILLEGAL: illegal=1, all enables 0, stays until reset.
- retired: +1 on the last cycle of each instruction (the cycle whose next state is FETCH, excluding reset). Wraps modulo 2^RET_W.
- Latency with zero wait states: R/ori/lui 4 cycles; lw 5; sw 4; beq/j/jal/jr 3.

Test Plan:
- reset=1 for 2 cycles, mem_ready=1 -> state_dbg=FETCH, all enables 0, retired=0; first release cycle: mem_req=1, ir_write=1, pc_write=1.
- addu (opcode 0, funct 100001) with mem_ready held 1 -> reg_write=1, reg_dst=1 exactly in cycle 4; retired=1 after cycle 4.
- lw with mem_ready delayed 3 cycles in FETCH and 2 in MEM_RD -> completes in 5+3+2=10 cycles; reg_write=1, mem_to_reg=1 in the last cycle only.
- beq with zero=1, then zero=0 -> pc_write_cond=1, pc_src=1 in cycle 3 both times; jal -> reg_dst=2, mem_to_reg=2, pc_src=2 in cycle 3.
- TIMEOUT=15, mem_ready never asserted -> fault=1 after cycle 15 of FETCH, stays sticky; reset then clears it. mem_ready on cycle 15 -> no fault.
- opcode 111111 -> illegal=1 the cycle after DECODE, mem_req stays 0; reset asserted mid-MEM_WR -> FETCH next cycle, mem_we=0.
